// File: rtl/tone_gen.sv
// Square-wave tone generator: picks the highest-priority requested key, adds a
// semitone shift, and plays the equal-tempered pitch with glitch-free period changes.
module tone_gen #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  note,
   input  logic [4:0]  pitchshift,
   output logic        audio_out,
   output logic        audio_sd,
   output logic        active,
   output logic [5:0]  cur_idx,
   output logic [17:0] half_period,
   output logic        dbg_state
);

   typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

   // Half-period in clocks for table index k, rounded to nearest (k=0 is C4).
   function automatic logic [17:0] hp_of(input int k);
      real r;
      int  v;
      r = real'(CLK_HZ) / (2.0 * 261.6256 * (2.0 ** (real'(k) / 12.0)));
      v = $rtoi(r + 0.5);
      return v[17:0];
   endfunction

   state_t      r_state;
   state_t      w_next_state;
   logic [9:0]  r_note_q;
   logic [4:0]  r_ps_q;
   logic        r_pend_valid;
   logic [5:0]  r_pend_idx;
   logic [17:0] r_pend_hp;
   logic [17:0] r_cnt;
   logic        r_audio;
   logic [5:0]  r_cur_idx;
   logic [17:0] r_hp;

   logic [3:0]  w_sel;
   logic        w_any;
   logic [5:0]  w_idx;
   logic [17:0] w_hp;
   logic [17:0] w_hp_rom [0:63];
   logic        w_load;
   logic        w_audio_nxt;
   logic [17:0] w_cnt_nxt;

   // Only indices 0..40 are reachable; the rest just fill the 6-bit address space.
   for (genvar k = 0; k < 64; k++) begin : g_rom
      assign w_hp_rom[k] = hp_of(k);
   end

   always_comb begin
      w_sel = 4'd0;
      for (int i = 9; i >= 0; i--) begin
         if (r_note_q[i]) w_sel = i[3:0];
      end
   end

   assign w_any = |r_note_q;
   assign w_idx = {2'b00, w_sel} + {1'b0, r_ps_q};
   assign w_hp  = w_hp_rom[w_idx];

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (r_pend_valid) w_next_state = S_PLAY;
         S_PLAY:  if (r_cnt == 18'd0 && !r_pend_valid) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Pending values are only taken at a half-period boundary (or from IDLE).
   always_comb begin
      w_load      = 1'b0;
      w_audio_nxt = r_audio;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            w_audio_nxt = 1'b0;
            if (r_pend_valid) begin
               w_load      = 1'b1;
               w_audio_nxt = 1'b1;
               w_cnt_nxt   = r_pend_hp - 18'd1;
            end
         end
         S_PLAY: begin
            if (r_cnt != 18'd0) begin
               w_cnt_nxt = r_cnt - 18'd1;
            end else if (r_pend_valid) begin
               w_load      = 1'b1;
               w_audio_nxt = ~r_audio;
               w_cnt_nxt   = r_pend_hp - 18'd1;
            end else begin
               w_audio_nxt = 1'b0;
            end
         end
         default: w_audio_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_note_q     <= '0;
         r_ps_q       <= '0;
         r_pend_valid <= 1'b0;
         r_pend_idx   <= '0;
         r_pend_hp    <= '0;
         r_cnt        <= '0;
         r_audio      <= 1'b0;
         r_cur_idx    <= '0;
         r_hp         <= '0;
      end else begin
         r_note_q     <= note;
         r_ps_q       <= pitchshift;
         r_pend_valid <= w_any;
         r_pend_idx   <= w_idx;
         r_pend_hp    <= w_hp;
         r_cnt        <= w_cnt_nxt;
         r_audio      <= w_audio_nxt;
         if (w_load) begin
            r_cur_idx <= r_pend_idx;
            r_hp      <= r_pend_hp;
         end
      end
   end

   assign audio_out   = r_audio;
   assign active      = (r_state == S_PLAY);
   assign audio_sd    = active;
   assign cur_idx     = r_cur_idx;
   assign half_period = r_hp;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen at CLK_HZ = 1 MHz: table of notes plus hand-timed sequences
// for glitch-free changes, late/early changes, release and reset mid-tone.
module tb_tone_gen;

   logic        clk;
   logic        rst;
   logic [9:0]  note;
   logic [4:0]  pitchshift;
   logic        audio_out;
   logic        audio_sd;
   logic        active;
   logic [5:0]  cur_idx;
   logic [17:0] half_period;
   logic        dbg_state;

   tone_gen #(.CLK_HZ(1_000_000)) dut (
      .clk         (clk),
      .rst         (rst),
      .note        (note),
      .pitchshift  (pitchshift),
      .audio_out   (audio_out),
      .audio_sd    (audio_sd),
      .active      (active),
      .cur_idx     (cur_idx),
      .half_period (half_period),
      .dbg_state   (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [9:0]  note;
      logic [4:0]  ps;
      logic [5:0]  exp_idx;
      logic [17:0] exp_hp;
   } vec_t;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [17:0] exp_q[$];
   logic        mon_en = 1'b0;
   int          ev_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Measures each completed half-period (audio edge, or PLAY ending while low)
   // and compares it with the next expected length.
   initial begin
      int          cyc;
      int          last_t;
      bit          start_v;
      logic        prev_a;
      logic        prev_act;
      logic [17:0] e;
      cyc = 0; last_t = 0; start_v = 1'b0; prev_a = 1'b0; prev_act = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!mon_en) begin
            start_v = 1'b0;
         end else if (audio_out !== prev_a || (prev_act && !active)) begin
            if (start_v && prev_act) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL half_period_len: got unexpected boundary after %0d cycles, expected none", cyc - last_t);
               end else begin
                  e = exp_q.pop_front();
                  if (cyc - last_t != int'(e)) begin
                     n_errors++;
                     $display("FAIL half_period_len: got %0d expected %0d", cyc - last_t, e);
                  end
               end
               ev_cnt++;
            end
            last_t  = cyc;
            start_v = 1'b1;
         end
         prev_a   = audio_out;
         prev_act = active;
      end
   end

   task automatic wait_event(input string name);
      int s;
      int n;
      s = ev_cnt;
      n = 0;
      while (ev_cnt == s && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (ev_cnt == s) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: got no boundary in 5000 cycles expected one", name);
      end
   endtask

   // Called at a negedge; drives the note and checks the 3-edge note-on latency.
   task automatic note_on(input logic [9:0] n, input logic [4:0] ps,
                          input logic [5:0] e_idx, input logic [17:0] e_hp);
      note       = n;
      pitchshift = ps;
      @(posedge clk); #1;
      check("on_e0_audio", audio_out, 0);
      @(posedge clk); #1;
      check("on_e1_audio", audio_out, 0);
      check("on_e1_active", active, 0);
      @(posedge clk); #1;
      check("on_e2_audio", audio_out, 1);
      check("on_e2_active", active, 1);
      check("on_e2_sd", audio_sd, 1);
      check("on_cur_idx", cur_idx, e_idx);
      check("on_half_period", half_period, e_hp);
      @(negedge clk);
   endtask

   task automatic release_note(input logic [17:0] last_hp, input logic [5:0] e_idx);
      note = '0;
      exp_q.push_back(last_hp);
      wait_event("release");
      check("rel_audio", audio_out, 0);
      check("rel_active", active, 0);
      check("rel_cur_idx", cur_idx, e_idx);
      check("rel_half_period", half_period, last_hp);
      repeat (20) @(negedge clk);
      check("rel_stay_idle", active, 0);
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{note: 10'b0000000001, ps: 5'd0,  exp_idx: 6'd0,  exp_hp: 18'd1911};
      vecs[1] = '{note: 10'b1000000100, ps: 5'd12, exp_idx: 6'd14, exp_hp: 18'd851};
      vecs[2] = '{note: 10'b1000000000, ps: 5'd31, exp_idx: 6'd40, exp_hp: 18'd190};
      vecs[3] = '{note: 10'b0000011000, ps: 5'd5,  exp_idx: 6'd8,  exp_hp: 18'd1204};
      vecs[4] = '{note: 10'b0100000000, ps: 5'd3,  exp_idx: 6'd11, exp_hp: 18'd1012};

      rst = 1'b1; note = '0; pitchshift = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_audio", audio_out, 0);
      check("rst_active", active, 0);
      check("rst_sd", audio_sd, 0);
      check("rst_cur_idx", cur_idx, 0);
      check("rst_half_period", half_period, 0);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_no_note", active, 0);

      for (int i = 0; i < 5; i++) begin
         note_on(vecs[i].note, vecs[i].ps, vecs[i].exp_idx, vecs[i].exp_hp);
         repeat (3) begin
            exp_q.push_back(vecs[i].exp_hp);
            wait_event("vec_hp");
         end
         release_note(vecs[i].exp_hp, vecs[i].exp_idx);
      end

      // Mid-half-period change: current half completes at the old length.
      note_on(10'b0000000001, 5'd0, 6'd0, 18'd1911);
      exp_q.push_back(18'd1911);
      wait_event("glitch_first");
      repeat (500) @(negedge clk);
      pitchshift = 5'd12;
      exp_q.push_back(18'd1911);
      exp_q.push_back(18'd956);
      exp_q.push_back(18'd956);
      repeat (3) wait_event("glitch_change");
      release_note(18'd956, 6'd12);

      // Change arriving 1 cycle before a boundary waits one more; 2 cycles before is taken.
      note_on(10'b0000000001, 5'd0, 6'd0, 18'd1911);
      exp_q.push_back(18'd1911);
      wait_event("late_first");
      repeat (1911 - 2) @(negedge clk);
      pitchshift = 5'd12;
      exp_q.push_back(18'd1911);
      exp_q.push_back(18'd1911);
      exp_q.push_back(18'd956);
      repeat (3) wait_event("late_change");
      repeat (956 - 3) @(negedge clk);
      pitchshift = 5'd0;
      exp_q.push_back(18'd956);
      exp_q.push_back(18'd1911);
      repeat (2) wait_event("early_change");
      release_note(18'd1911, 6'd0);

      // Reset while audio is high, then restart with the note still held.
      note_on(10'b0000000001, 5'd0, 6'd0, 18'd1911);
      repeat (100) @(negedge clk);
      check("pre_rst_audio", audio_out, 1);
      mon_en = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_audio", audio_out, 0);
      check("midrst_active", active, 0);
      check("midrst_cur_idx", cur_idx, 0);
      check("midrst_half_period", half_period, 0);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;
      check("restart_e0_audio", audio_out, 0);
      @(posedge clk); #1;
      check("restart_e1_audio", audio_out, 0);
      @(posedge clk); #1;
      check("restart_e2_audio", audio_out, 1);
      check("restart_e2_active", active, 1);
      check("restart_half_period", half_period, 1911);
      @(negedge clk);
      exp_q.push_back(18'd1911);
      wait_event("restart_hp");
      release_note(18'd1911, 6'd0);

      check("exp_q_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
